// File: rtl/prio_enc_pkg.sv
// Shared constants and reference helpers for the fixed-priority encoder.
// Bit PE_WIDTH-1 is the highest priority.
package prio_enc_pkg;

  localparam int PE_WIDTH = 4;
  localparam int PE_OUT_W = 2;

  localparam logic [PE_OUT_W-1:0] PE_OUT_RST   = 2'b00;
  localparam logic                PE_VALID_RST = 1'b0;

  // Index of the highest set bit. An all-zero vector returns 0, so callers
  // must qualify the result with an OR-reduction of the vector.
  function automatic logic [PE_OUT_W-1:0] pe_highest_idx(input logic [PE_WIDTH-1:0] vec);
    logic [PE_OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PE_WIDTH; i++) begin
      if (vec[i]) idx = PE_OUT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority core: index of the highest set request bit plus
// an any-request flag.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // Scan from the top; the first hit wins and masks every lower bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!any && in[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_4.sv
// Registered fixed-priority encoder: one-cycle latency, enable-gated
// capture, asynchronous active-low clear.
module priority_encoder_4
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("priority_encoder_4: WIDTH must be a power of two and at least 2");
  end

  logic [OUT_W-1:0] idx;
  logic             any;

  prio_enc_core #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) u_core (
    .in (in),
    .idx(idx),
    .any(any)
  );

  // Interface contract: en=1 captures the request vector on the rising edge
  // and the result appears one cycle later; en=0 holds out/valid. valid=0
  // means "no request", so out is only meaningful while valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= OUT_W'(PE_OUT_RST);
      valid <= PE_VALID_RST;
    end else if (en) begin
      out   <= idx;
      valid <= any;
    end
  end

endmodule

// File: tb/tb_priority_encoder_4.sv
// Self-checking bench for priority_encoder_4: directed plan plus randomized
// traffic compared every cycle against a behavioural model.
module tb_priority_encoder_4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] in    = 4'b0000;
  logic [1:0] out;
  logic       valid;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [1:0] mdl_out   = 2'b00;
  logic       mdl_valid = 1'b0;

  priority_encoder_4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (in),
    .out  (out),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // Highest set bit of a nonzero value is clog2(v+1)-1.
  function automatic logic [1:0] model_idx(input logic [3:0] v);
    int n;
    n = int'(v);
    if (n == 0) return 2'b00;
    return 2'($clog2(n + 1) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_out   <= 2'b00;
      mdl_valid <= 1'b0;
    end else if (en) begin
      mdl_out   <= model_idx(in);
      mdl_valid <= (in != 4'b0000);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (out !== mdl_out || valid !== mdl_valid) begin
        errors++;
        $display("FAIL model_cmp t=%0t out=%b valid=%b expected out=%b valid=%b",
                 $time, out, valid, mdl_out, mdl_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] exp_o, input logic exp_v);
    checks++;
    if (out !== exp_o || valid !== exp_v) begin
      errors++;
      $display("FAIL %s out=%b valid=%b expected out=%b valid=%b",
               name, out, valid, exp_o, exp_v);
    end
  endtask

  // Drive away from the edge, then land just after the capturing edge.
  task automatic step(input logic [3:0] v, input logic e);
    @(negedge clk);
    #1;
    in = v;
    en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] table_idx(input int v);
    if (v < 2) return 2'b00;
    if (v < 4) return 2'b01;
    if (v < 8) return 2'b10;
    return 2'b11;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    in = 4'b1000;
    en = 1'b1;
    @(posedge clk);
    #1;
    cmp_on = 1'b1;

    // Reset holds outputs low despite a live request.
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 1'b1);
      chk("reset_hold", 2'b00, 1'b0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", 2'b11, 1'b1);

    // Exhaustive sweep.
    for (int v = 0; v < 16; v++) begin
      step(4'(v), 1'b1);
      chk($sformatf("sweep_%0d", v), table_idx(v), v != 0);
    end

    // Enable hold.
    step(4'b0100, 1'b1);
    chk("hold_load", 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b1000, 1'b0);
      chk("hold_en0", 2'b10, 1'b1);
    end
    step(4'b1000, 1'b1);
    chk("hold_resume", 2'b11, 1'b1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", 2'b00, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Priority masking.
    step(4'b1111, 1'b1);
    chk("mask_1111", 2'b11, 1'b1);
    step(4'b0111, 1'b1);
    chk("mask_0111", 2'b10, 1'b1);
    step(4'b0011, 1'b1);
    chk("mask_0011", 2'b01, 1'b1);
    step(4'b0001, 1'b1);
    chk("mask_0001", 2'b00, 1'b1);
    step(4'b0000, 1'b1);
    chk("mask_0000", 2'b00, 1'b0);

    // Back-to-back alternation.
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 4'b1000 : 4'b0001, 1'b1);
      chk("b2b", (i % 2 == 0) ? 2'b11 : 2'b00, 1'b1);
    end

    // Random traffic with occasional enable drops and reset pulses.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      in = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 29) != 0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
